imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: receives a byte stream (word count, little-endian instruction words, XOR checksum)
// and writes the words into instruction memory, holding the core in reset until the load succeeds.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Counts up to and including the full depth need one bit more than the address.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;

  logic              accept;
  logic [15:0]       n_in;
  logic [ADDR_W:0]   wr_next;

  assign accept  = in_valid & in_ready;
  assign n_in    = {in_data, cnt_lo_q};
  assign wr_next = wr_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CNT_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CNT_LO: if (accept) state_d = S_CNT_HI;
      S_CNT_HI: begin
        if (accept) begin
          if ({1'b0, n_in} > DEPTH) begin
            state_d = S_ERROR;
          end else if (n_in == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA:   if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE:  state_d = (17'(wr_next) < {1'b0, n_q}) ? S_DATA : S_CHECK;
      S_CHECK:  if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      S_DONE:   state_d = S_DONE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_CNT_LO;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: in_ready = 1'b1;
      S_WRITE: imem_we = 1'b1;
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = wr_cnt_q[ADDR_W-1:0];
  assign imem_wdata = word_q;

  // Bytes shift in from the top so the first byte of a word ends up in bits 7:0.
  always_comb begin
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    wr_cnt_d   = wr_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    case (state_q)
      S_CNT_LO: if (accept) cnt_lo_d = in_data;
      S_CNT_HI: if (accept) n_d = n_in;
      S_DATA: begin
        if (accept) begin
          word_d     = {in_data, word_q[31:8]};
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      S_WRITE: wr_cnt_d = wr_next;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo_q   <= '0;
      n_q        <= '0;
      byte_idx_q <= '0;
      wr_cnt_q   <= '0;
      word_q     <= '0;
      csum_q     <= '0;
    end else begin
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      wr_cnt_q   <= wr_cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte streams built from a word list, expected writes and final
// status derived from the stream format rules, writes captured from the memory port.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  stream[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  logic [4:0]  exp_status;   // {done, error, cpu_reset, in_ready, imem_we}

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    got_addr.delete();
    got_data.delete();
    reset = 1'b0;
  endtask

  // Reference model: words -> stream bytes, expected writes and terminal status.
  task automatic build(input int n, input logic [31:0] words[$], input bit good_cs);
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (n > (1 << ADDR_W)) begin
      exp_status = 5'b01100;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        stream.push_back(words[i][8*b +: 8]);
        x = x ^ words[i][8*b +: 8];
      end
      exp_addr.push_back(i);
      exp_data.push_back(words[i]);
    end
    stream.push_back(good_cs ? x : ~x);
    exp_status = good_cs ? 5'b10000 : 5'b01100;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every byte, 2 random idle runs
  task automatic send_stream(input int gap_mode);
    bit acc;
    int tries;
    foreach (stream[i]) begin
      if (gap_mode == 1) begin
        @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
        end
      end
      acc = 1'b0;
      tries = 0;
      while (!acc) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data = stream[i];
        acc = in_ready;
        tries++;
        if (!acc && tries > 8) begin
          n_checks++;
          $display("FAIL stall byte %0d: in_ready=%b required 1", i, in_ready);
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error} !==
        {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b required 1 0 0 0 1 0 0",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error);
    end else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_example(input int gap_mode, input string tag);
    logic [31:0] w[$];
    w = '{32'h00100013, 32'h00200093};
    do_reset();
    build(2, w, 1'b1);
    n_checks++;
    // checksum is the XOR of the eight data bytes: 13^10^93^20 = B0
    if (stream[10] !== 8'hB0) $display("FAIL %s_csum_byte: got %h required b0", tag, stream[10]);
    else n_pass++;
    send_stream(gap_mode);
    n_checks++;
    if ({done, error, cpu_reset, in_ready, imem_we} !== exp_status)
      $display("FAIL %s_status: got %b required %b", tag, {done, error, cpu_reset, in_ready, imem_we}, exp_status);
    else n_pass++;
    n_checks++;
    if (got_addr.size() != 2) $display("FAIL %s_nwrites: got %0d required 2", tag, got_addr.size());
    else begin
      n_pass++;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i])
          $display("FAIL %s_write%0d: got %0d:%h required %0d:%h", tag, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_empty();
    logic [31:0] w[$];
    do_reset();
    build(0, w, 1'b1);
    send_stream(0);
    n_checks++;
    if ({done, error, cpu_reset, in_ready, imem_we} !== 5'b10000)
      $display("FAIL empty_status: got %b required 10000", {done, error, cpu_reset, in_ready, imem_we});
    else n_pass++;
    n_checks++;
    if (got_addr.size() != 0) $display("FAIL empty_nwrites: got %0d required 0", got_addr.size());
    else n_pass++;
  endtask

  task automatic test_oversize();
    logic [31:0] w[$];
    do_reset();
    build(257, w, 1'b1);
    send_stream(0);
    n_checks++;
    if ({done, error, cpu_reset, in_ready, imem_we} !== 5'b01100)
      $display("FAIL oversize_status: got %b required 01100", {done, error, cpu_reset, in_ready, imem_we});
    else n_pass++;
    n_checks++;
    if (got_addr.size() != 0) $display("FAIL oversize_nwrites: got %0d required 0", got_addr.size());
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    logic [31:0] w[$];
    w = '{32'h12345678};
    do_reset();
    build(1, w, 1'b0);
    stream[6] = 8'hFF;   // correct XOR is 12^34^56^78 = 08
    send_stream(0);
    n_checks++;
    if ({done, error, cpu_reset, in_ready, imem_we} !== 5'b01100)
      $display("FAIL badcs_status: got %b required 01100", {done, error, cpu_reset, in_ready, imem_we});
    else n_pass++;
    n_checks++;
    if (got_addr.size() != 1 || got_addr[0] != 0 || got_data[0] !== 32'h12345678)
      $display("FAIL badcs_write: got n=%0d %h required n=1 0:12345678", got_addr.size(),
               (got_data.size() > 0) ? got_data[0] : 32'h0);
    else n_pass++;
  endtask

  task automatic test_reset_midword();
    logic [31:0] w[$];
    w = '{32'h00100013, 32'h00200093};
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00};
    send_stream(0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, imem_wdata} !== {1'b1, 32'h0})
      $display("FAIL midreset_clear: rdy=%b wdata=%h required 1 00000000", in_ready, imem_wdata);
    else n_pass++;
    do_reset();
    build(2, w, 1'b1);
    send_stream(0);
    n_checks++;
    if ({done, error, cpu_reset, in_ready, imem_we} !== 5'b10000)
      $display("FAIL midreset_status: got %b required 10000", {done, error, cpu_reset, in_ready, imem_we});
    else n_pass++;
    n_checks++;
    if (got_addr.size() != 2 || got_data[0] !== 32'h00100013 || got_data[1] !== 32'h00200093 || got_addr[1] != 1)
      $display("FAIL midreset_writes: got n=%0d required 2 writes 00100013,00200093", got_addr.size());
    else n_pass++;
  endtask

  task automatic test_full_depth();
    logic [31:0] w[$];
    int bad;
    for (int i = 0; i < (1 << ADDR_W); i++) w.push_back($urandom);
    do_reset();
    build(1 << ADDR_W, w, 1'b1);
    send_stream(0);
    n_checks++;
    if ({done, error, cpu_reset, in_ready, imem_we} !== 5'b10000)
      $display("FAIL full_status: got %b required 10000", {done, error, cpu_reset, in_ready, imem_we});
    else n_pass++;
    n_checks++;
    if (got_addr.size() != exp_addr.size()) begin
      $display("FAIL full_nwrites: got %0d required %0d", got_addr.size(), exp_addr.size());
    end else begin
      n_pass++;
      bad = 0;
      for (int i = 0; i < got_addr.size(); i++)
        if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL full_writes: %0d wrong, required 0", bad);
      else n_pass++;
      n_checks++;
      if (got_addr[got_addr.size()-1] != (1 << ADDR_W) - 1)
        $display("FAIL full_last_addr: got %0d required %0d", got_addr[got_addr.size()-1], (1 << ADDR_W) - 1);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    int n;
    bit good;
    for (int it = 0; it < 10; it++) begin
      w.delete();
      n = (it == 9) ? int'($urandom_range(257, 65535)) : int'($urandom_range(0, 6));
      good = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < n && i < 16; i++) w.push_back($urandom);
      do_reset();
      build(n, w, good);
      send_stream(2);
      n_checks++;
      if ({done, error, cpu_reset, in_ready, imem_we} !== exp_status)
        $display("FAIL rand%0d_status: got %b required %b", it, {done, error, cpu_reset, in_ready, imem_we}, exp_status);
      else n_pass++;
      n_checks++;
      if (got_addr.size() != exp_addr.size()) begin
        $display("FAIL rand%0d_nwrites: got %0d required %0d", it, got_addr.size(), exp_addr.size());
      end else begin
        n_pass++;
        for (int i = 0; i < got_addr.size(); i++) begin
          n_checks++;
          if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i])
            $display("FAIL rand%0d_write%0d: got %0d:%h required %0d:%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_example(0, "example");
    test_empty();
    test_oversize();
    test_bad_checksum();
    test_example(1, "gaps");
    test_reset_midword();
    test_full_depth();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
